// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding,
// parity-mode codes, bit-period calculation and the parity function.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Integer division truncates, so the real baud rate is never slower than requested.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic parity_of(input logic [7:0] data, input int mode);
    logic even_s;
    even_s = ^data;
    if (mode == PAR_ODD) begin
      return ~even_s;
    end else begin
      return even_s;
    end
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while the transmitter is busy and
// flags the last cycle of each bit so the FSM can advance.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  logic [CW-1:0] cnt_r;

  // Cycle counter; held at zero outside a frame so every frame starts aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= ZERO;
    end else if (restart || !run || (cnt_r == LAST)) begin
      cnt_r <= ZERO;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

  assign tick = run && !restart && (cnt_r == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even/odd parity,
// 1 or 2 stop bits. tx and tx_busy are registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int INPUT_CLK  = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_BIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(INPUT_CLK, BAUD_RATE);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if ((PARITY_BIT < PAR_NONE) || (PARITY_BIT > PAR_ODD)) begin : g_bad_parity
    $error("uart_tx: PARITY_BIT must be 0, 1 or 2");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_baud
    $error("uart_tx: INPUT_CLK / BAUD_RATE must be at least 1");
  end

  uart_state_e state_r, state_s;
  logic [2:0]  bit_idx_r, bit_idx_s, idx_next_s;
  logic [7:0]  data_r, data_s;
  logic        parity_r, parity_s;
  logic        tx_r, tx_s;
  logic        busy_r, busy_s;
  logic        restart_s;
  logic        tick_s;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(restart_s),
    .run    (state_r != IDLE),
    .tick   (tick_s)
  );

  assign idx_next_s = bit_idx_r + 3'd1;

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_s   = state_r;
    bit_idx_s = bit_idx_r;
    data_s    = data_r;
    parity_s  = parity_r;
    tx_s      = tx_r;
    busy_s    = busy_r;
    restart_s = 1'b0;
    case (state_r)
      IDLE: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
        if (tx_start) begin
          data_s    = tx_data;
          parity_s  = parity_of(tx_data, PARITY_BIT);
          tx_s      = 1'b0;
          busy_s    = 1'b1;
          bit_idx_s = 3'd0;
          restart_s = 1'b1;
          state_s   = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          tx_s      = data_r[0];
          bit_idx_s = 3'd0;
          state_s   = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
            if (PARITY_BIT != PAR_NONE) begin
              tx_s    = parity_r;
              state_s = PARITY;
            end else begin
              tx_s    = 1'b1;
              state_s = STOP;
            end
          end else begin
            bit_idx_s = idx_next_s;
            tx_s      = data_r[idx_next_s];
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          tx_s      = 1'b1;
          bit_idx_s = 3'd0;
          state_s   = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        // bit_idx_r counts stop-bit periods here.
        if (tick_s) begin
          if (bit_idx_r == LAST_STOP) begin
            tx_s      = 1'b1;
            busy_s    = 1'b0;
            bit_idx_s = 3'd0;
            state_s   = IDLE;
          end else begin
            bit_idx_s = idx_next_s;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        tx_s      = 1'b1;
        busy_s    = 1'b0;
        bit_idx_s = 3'd0;
        state_s   = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      bit_idx_r <= 3'd0;
      data_r    <= 8'h00;
      parity_r  <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_idx_r <= bit_idx_s;
      data_r    <= data_s;
      parity_r  <= parity_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
    end
  end

  assign tx      = tx_r;
  assign tx_busy = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames checked cycle by cycle, plus
// hand-written reset, idle and mid-frame-request sequences.
module tb_uart_tx;

  localparam int CPB = 868;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00, data2 = 8'h00;
  logic tx0, tx1, tx2, busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx dut0 (.clk(clk), .reset(reset), .tx_start(start0), .tx_data(data0),
                .tx_busy(busy0), .tx(tx0));
  uart_tx #(.PARITY_BIT(1), .STOP_BITS(2)) dut1 (.clk(clk), .reset(reset),
                .tx_start(start1), .tx_data(data1), .tx_busy(busy1), .tx(tx1));
  uart_tx #(.PARITY_BIT(2), .STOP_BITS(1)) dut2 (.clk(clk), .reset(reset),
                .tx_start(start2), .tx_data(data2), .tx_busy(busy2), .tx(tx2));

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [11:0] exp_bits;  // bit i = i-th bit on the line
    int          nbits;
    int          hold;
  } vec_t;

  vec_t vecs [6];

  function automatic logic get_tx(input int sel);
    case (sel)
      0: return tx0;
      1: return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic set_data(input int sel, input logic [7:0] d);
    case (sel)
      0: data0 = d;
      1: data1 = d;
      default: data2 = d;
    endcase
  endtask

  task automatic check(input string what, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", what, got, exp);
    end
  endtask

  // Sends one frame and compares tx/tx_busy on every cycle of it. tx_start is
  // held for `hold` edges; if poke >= 0 a stray request plus new data is
  // applied at that cycle of the frame.
  task automatic run_frame(input int sel, input logic [7:0] data,
                           input logic [11:0] exp_bits, input int nbits,
                           input int hold, input int poke, input string name);
    int n;
    int bad_tx;
    int bad_busy;
    int first_bad;
    int bit_i;
    n = nbits * CPB;
    bad_tx = 0;
    bad_busy = 0;
    first_bad = -1;
    @(negedge clk);
    set_data(sel, data);
    set_start(sel, 1'b1);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (c + 1 == hold) set_start(sel, 1'b0);
      if (c == poke) begin
        set_start(sel, 1'b1);
        set_data(sel, ~data);
      end
      if (c == poke + 1) set_start(sel, 1'b0);
      bit_i = c / CPB;
      if (get_tx(sel) !== exp_bits[bit_i]) begin
        bad_tx++;
        if (first_bad < 0) first_bad = c;
      end
      if (get_busy(sel) !== 1'b1) bad_busy++;
    end
    check($sformatf("%s tx bits (first bad cycle %0d)", name, first_bad), bad_tx, 0);
    check($sformatf("%s busy high cycles", name), n - bad_busy, n);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s busy low after frame +%0d", name, k), int'(get_busy(sel)), 0);
      check($sformatf("%s tx idle after frame +%0d", name, k), int'(get_tx(sel)), 1);
    end
  endtask

  task automatic idle_watch(input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if ((tx0 !== 1'b1) || (busy0 !== 1'b0)) bad++;
    end
    check("idle line cycles wrong", bad, 0);
  endtask

  initial begin
    vecs[0] = '{0, 8'h3D, {2'b00, 1'b1, 8'h3D, 1'b0}, 10, 2};
    vecs[1] = '{0, 8'hC3, {2'b00, 1'b1, 8'hC3, 1'b0}, 10, 1};
    vecs[2] = '{0, 8'hAA, {2'b00, 1'b1, 8'hAA, 1'b0}, 10, 1};
    vecs[3] = '{0, 8'h55, {2'b00, 1'b1, 8'h55, 1'b0}, 10, 1};
    vecs[4] = '{1, 8'hAA, {2'b11, 1'b0, 8'hAA, 1'b0}, 12, 1};
    vecs[5] = '{2, 8'hAA, {1'b0, 1'b1, 1'b1, 8'hAA, 1'b0}, 11, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset tx0", int'(tx0), 1);
    check("reset busy0", int'(busy0), 0);
    check("reset tx1", int'(tx1), 1);
    check("reset busy1", int'(busy1), 0);
    @(negedge clk);
    reset = 1'b0;

    // Idle watch on dut0 runs alongside the parity-variant frames.
    fork
      idle_watch(20000);
      begin
        for (int i = 4; i < 6; i++) begin
          run_frame(vecs[i].sel, vecs[i].data, vecs[i].exp_bits, vecs[i].nbits,
                    vecs[i].hold, -1, $sformatf("frame[%0d]", i));
        end
      end
    join

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].exp_bits, vecs[i].nbits,
                vecs[i].hold, -1, $sformatf("frame[%0d]", i));
    end

    // Stray request and data change in the middle of the data bits.
    run_frame(0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 1, 4 * CPB + 17, "midframe");

    // Reset during DATA aborts the frame on the next edge.
    @(negedge clk);
    data0 = 8'hFF;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    check("pre-reset busy", int'(busy0), 1);
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort tx", int'(tx0), 1);
    check("abort busy", int'(busy0), 0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(0, 8'h96, {2'b00, 1'b1, 8'h96, 1'b0}, 10, 1, -1, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Parameterised UART transmitter: serialises one byte per request onto a single idle-high line.
- Frame order: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Sits between a byte-producing client (holds data, pulses tx_start, polls tx_busy) and the board TX pin.
- Bit timing is derived from the system clock by an integer cycle counter.

Parameters:
INPUT_CLK, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s; CLKS_PER_BIT = INPUT_CLK / BAUD_RATE, integer division (868 at defaults)
STOP_BITS, 1, number of stop bits; legal values 1 or 2
PARITY_BIT, 0, 0 = no parity, 1 = even parity, 2 = odd parity

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
tx_start  input  1  transmit request, level-sampled only while idle
tx_data  input  8  byte to send, captured when a request is accepted
tx_busy  output  1  high from request acceptance until the last stop bit ends
tx  output  1  serial line; idle high

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Outputs tx and tx_busy are registered.
- Reset values: tx=1, tx_busy=0, state=IDLE, bit counter=0, cycle counter=0.
- Reset has priority over all other inputs, including mid-frame: the frame aborts and the line returns to 1 on the next edge.
- State machine states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_busy=0.
  - If tx_start=1 at a rising edge: latch tx_data into a shift register, then set tx=0, tx_busy=1, state=START and clear the cycle counter, all at that same edge.
  - Latency: tx falls and tx_busy rises one edge after tx_start is sampled.
- Bit timing: every state other than IDLE holds tx for exactly CLKS_PER_BIT cycles. The cycle counter counts 0..CLKS_PER_BIT-1; at the terminal count the FSM advances and the counter clears.
- START -> DATA: drive data bit 0 first.
- DATA: 8 bits, LSB first; bit index 0..7.
  - After bit 7, go to PARITY if PARITY_BIT != 0, else to STOP.
- PARITY: drives the parity bit.
  - Even parity = XOR of the 8 latched data bits.
  - Odd parity = the inverse of that.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. Then state=IDLE and tx_busy=0 at the same edge.
- tx_start while busy is ignored; no queuing.
- tx_start still high on the IDLE-return cycle or later starts a new frame; a back-to-back frame is legal.
- tx_data changes while busy have no effect on the frame in flight.
- Frame length (cycles) = CLKS_PER_BIT*(1+8+P+STOP_BITS), where P = 1 if parity is enabled, else 0. At defaults: 10*868 = 8680 cycles.
- Illegal parameter values (STOP_BITS not 1/2, PARITY_BIT > 2, CLKS_PER_BIT < 1) are elaboration errors.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), parity-mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2), and a function computing CLKS_PER_BIT.
- One sub-module, uart_baud_tick:
  - Counts to CLKS_PER_BIT-1 and emits a one-cycle tick.
  - Cleared by reset or by a restart input pulsed when the FSM leaves IDLE.
  - The FSM advances on the tick.

Test Plan:
- Defaults, tx_data=8'b00111101, tx_start held 2 cycles -> tx low 868 cycles, then bits 1,0,1,1,1,1,0,0 at 868 cycles each, then high. tx_busy high for exactly 8680 cycles; exactly one frame is sent.
- Back-to-back bytes 8'hC3, 8'hAA, 8'h55, each sent after tx_busy falls -> correct LSB-first bit patterns; tx stays 1 between frames.
- PARITY_BIT=1, STOP_BITS=2, byte 8'hAA -> parity bit 0; stop high for 1736 cycles; busy lasts 12*868 cycles. PARITY_BIT=2 -> parity bit 1.
- tx_start pulsed and tx_data changed mid-frame -> current frame unchanged; no second frame is started.
- Reset asserted during DATA -> next edge: tx=1, tx_busy=0. A subsequent tx_start sends a full clean frame.
- Idle after reset with tx_start=0 for 20000 cycles -> tx=1, tx_busy=0 throughout.
